// File: rtl/baud_gen_frac.sv
// Fractional baud generator for a 16550-class UART.
// prescaler (psd+1) -> divisor counter (L enables per sample) -> sample index (osr+1 per bit).
// Optional macro BAUD_FRAC_EN adds the fractional accumulator that stretches
// a sample period by one enable whenever acc+dlf carries out.
//
// state | meaning
// IDLE  | generator stopped, outputs low
// LOAD  | one-cycle restart: counters and accumulator cleared, ticks suppressed
// RUN   | generating sample_tick / baud_tick
module baud_gen_frac #(
   parameter int DL_WIDTH   = 16,
   parameter int PSD_WIDTH  = 4,
   parameter int FRAC_WIDTH = 4,
   parameter int OSR_WIDTH  = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DL_WIDTH-1:0]  divisor_latch,
   input  logic [PSD_WIDTH-1:0] psd,
   input  logic [FRAC_WIDTH-1:0] dlf,
   input  logic [OSR_WIDTH-1:0] osr,
   input  logic                 new_baud,
   output logic                 baud_tick,
   output logic                 sample_tick,
   output logic [OSR_WIDTH-1:0] sample_idx,
   output logic                 active
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [DL_WIDTH-1:0]   div_s_q, div_s_d;
   logic [PSD_WIDTH-1:0]  psd_s_q, psd_s_d;
   logic [OSR_WIDTH-1:0]  osr_s_q, osr_s_d;
   logic [PSD_WIDTH-1:0]  pc_q, pc_d;
   logic [DL_WIDTH:0]     dc_q, dc_d;
   logic [DL_WIDTH:0]     len_q, len_d;
   logic [OSR_WIDTH-1:0]  idx_q, idx_d;
   logic                  sample_tick_q, sample_tick_d;
   logic                  baud_tick_q, baud_tick_d;
   logic                  active_q, active_d;
   logic                  en_now;
   logic                  period_start;
   logic                  carry;

`ifdef BAUD_FRAC_EN
   logic [FRAC_WIDTH-1:0] dlf_s_q, dlf_s_d;
   logic [FRAC_WIDTH-1:0] acc_q, acc_d;
   logic [FRAC_WIDTH-1:0] acc_sum;
`else
   logic unused_dlf;
   assign unused_dlf = ^dlf;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: new_baud always restarts through LOAD
   always_comb begin
      state_d = state_q;
      if (new_baud) begin
         state_d = ST_LOAD;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_LOAD: state_d = (div_s_q != '0) ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Shadow configuration, captured only on new_baud; osr clamped to 3 minimum
   always_comb begin
      div_s_d = div_s_q;
      psd_s_d = psd_s_q;
      osr_s_d = osr_s_q;
`ifdef BAUD_FRAC_EN
      dlf_s_d = dlf_s_q;
`endif
      if (new_baud) begin
         div_s_d = divisor_latch;
         psd_s_d = psd;
         osr_s_d = (osr < OSR_WIDTH'(3)) ? OSR_WIDTH'(3) : osr;
`ifdef BAUD_FRAC_EN
         dlf_s_d = dlf;
`endif
      end
   end

   // Counters for the next cycle; a period starts on RUN entry or after each sample tick
   always_comb begin
      en_now       = (pc_q == psd_s_q);
      pc_d         = pc_q;
      dc_d         = dc_q;
      idx_d        = idx_q;
      len_d        = len_q;
      period_start = 1'b0;
      carry        = 1'b0;
`ifdef BAUD_FRAC_EN
      acc_d        = acc_q;
      acc_sum      = '0;
`endif
      if (state_d == ST_RUN) begin
         if (state_q == ST_RUN) begin
            pc_d = en_now ? '0 : pc_q + PSD_WIDTH'(1);
            if (sample_tick_q) begin
               dc_d         = '0;
               period_start = 1'b1;
               idx_d        = (idx_q == osr_s_q) ? '0 : idx_q + OSR_WIDTH'(1);
            end else if (en_now) begin
               dc_d = dc_q + (DL_WIDTH+1)'(1);
            end
         end else begin
            pc_d         = '0;
            dc_d         = '0;
            idx_d        = '0;
            period_start = 1'b1;
         end
      end else begin
         pc_d  = '0;
         dc_d  = '0;
         idx_d = '0;
         len_d = '0;
`ifdef BAUD_FRAC_EN
         acc_d = '0;
`endif
      end
      if (period_start) begin
`ifdef BAUD_FRAC_EN
         {carry, acc_sum} = {1'b0, acc_q} + {1'b0, dlf_s_q};
         acc_d            = acc_sum;
`endif
         len_d = {1'b0, div_s_q} + {{DL_WIDTH{1'b0}}, carry};
      end
   end

   // FSM outputs: decode next-cycle tick so the outputs come straight from flops
   always_comb begin
      active_d      = (state_d == ST_RUN);
      sample_tick_d = active_d && (pc_d == psd_s_q) &&
                      ((dc_d + (DL_WIDTH+1)'(1)) == len_d);
      baud_tick_d   = sample_tick_d && (idx_d == osr_s_q);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         div_s_q       <= '0;
         psd_s_q       <= '0;
         osr_s_q       <= '0;
         pc_q          <= '0;
         dc_q          <= '0;
         len_q         <= '0;
         idx_q         <= '0;
         sample_tick_q <= 1'b0;
         baud_tick_q   <= 1'b0;
         active_q      <= 1'b0;
`ifdef BAUD_FRAC_EN
         dlf_s_q       <= '0;
         acc_q         <= '0;
`endif
      end else begin
         div_s_q       <= div_s_d;
         psd_s_q       <= psd_s_d;
         osr_s_q       <= osr_s_d;
         pc_q          <= pc_d;
         dc_q          <= dc_d;
         len_q         <= len_d;
         idx_q         <= idx_d;
         sample_tick_q <= sample_tick_d;
         baud_tick_q   <= baud_tick_d;
         active_q      <= active_d;
`ifdef BAUD_FRAC_EN
         dlf_s_q       <= dlf_s_d;
         acc_q         <= acc_d;
`endif
      end
   end

   assign sample_tick = sample_tick_q;
   assign baud_tick   = baud_tick_q;
   assign sample_idx  = idx_q;
   assign active      = active_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: tick schedule model from cumulative period sums,
// per-cycle compare plus directed literal checks.
module tb_baud_gen_frac;
   localparam int DLW = 16;
   localparam int PW  = 4;
   localparam int FW  = 4;
   localparam int OW  = 5;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           new_baud = 1'b0;
   logic [DLW-1:0] divisor_latch = '0;
   logic [PW-1:0]  psd = '0;
   logic [FW-1:0]  dlf = '0;
   logic [OW-1:0]  osr = '0;
   logic           baud_tick, sample_tick, active;
   logic [OW-1:0]  sample_idx;

   int n_chk  = 0;
   int n_fail = 0;

   baud_gen_frac #(.DL_WIDTH(DLW), .PSD_WIDTH(PW), .FRAC_WIDTH(FW), .OSR_WIDTH(OW)) dut (
      .clk(clk), .reset(reset), .divisor_latch(divisor_latch), .psd(psd), .dlf(dlf),
      .osr(osr), .new_baud(new_baud), .baud_tick(baud_tick), .sample_tick(sample_tick),
      .sample_idx(sample_idx), .active(active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   int m_state = 0;   // 0 idle, 1 load, 2 run
   int m_n = 0;       // RUN cycle number, first RUN cycle is 1
   int m_div = 0, m_psd = 0, m_dlf = 0, m_osr = 0;
   bit started = 0;

   always @(posedge clk) begin
      started <= 1'b1;
      if (reset) begin
         m_state <= 0; m_n <= 0;
         m_div <= 0; m_psd <= 0; m_dlf <= 0; m_osr <= 0;
      end else if (new_baud) begin
         m_div   <= int'(divisor_latch);
         m_psd   <= int'(psd);
         m_dlf   <= int'(dlf);
         m_osr   <= (osr < 3) ? 3 : int'(osr);
         m_state <= 1;
         m_n     <= 0;
      end else begin
         case (m_state)
            1: begin m_state <= (m_div != 0) ? 2 : 0; m_n <= 1; end
            2: m_n <= m_n + 1;
            default: ;
         endcase
      end
   end

   // length in enables of the k-th sample period (k from 1)
   function automatic int per_len(input int k);
      int l;
      l = m_div;
`ifdef BAUD_FRAC_EN
      l += ((k * m_dlf) >> FW) - (((k - 1) * m_dlf) >> FW);
`endif
      return l;
   endfunction

   // number of sample ticks at RUN cycles 1..n
   function automatic int ticks_upto(input int n);
      int t, k;
      t = 0; k = 0;
      while (1) begin
         t += (m_psd + 1) * per_len(k + 1);
         if (t > n) break;
         k++;
      end
      return k;
   endfunction

   always @(negedge clk) begin
      if (started) begin
         int c, p, e_idx;
         logic e_tick, e_baud, e_act;
         e_tick = 0; e_baud = 0; e_act = 0; e_idx = 0;
         if (m_state == 2) begin
            c      = ticks_upto(m_n);
            p      = ticks_upto(m_n - 1);
            e_tick = (c != p);
            e_idx  = p % (m_osr + 1);
            e_baud = e_tick && (e_idx == m_osr);
            e_act  = 1;
         end
         chk("cycle_outputs", {active, baud_tick, sample_tick, 24'(sample_idx)},
             {e_act, e_baud, e_tick, 24'(e_idx)});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // cycles until the next tick (sel=1: baud_tick); returns bound on timeout
   task automatic wait_tick(input bit sel, input int bound, output int c);
      c = 0;
      do begin
         cyc(1);
         c++;
      end while (!(sel ? baud_tick : sample_tick) && c < bound);
   endtask

   task automatic start(input int dv, input int ps, input int df, input int os);
      divisor_latch = DLW'(dv); psd = PW'(ps); dlf = FW'(df); osr = OW'(os);
      new_baud = 1'b1;
      cyc(1);
      new_baud = 1'b0;
   endtask

   initial begin
      int c, c2;
      cyc(2);
      chk("reset_outputs", {active, baud_tick, sample_tick, 24'(sample_idx)}, 0);
      reset = 1'b0;

      // divisor 2, psd 1, osr 3
      start(2, 1, 0, 3);
      chk("load_active", active, 0);
      cyc(1);
      chk("run1_active", active, 1);
      wait_tick(0, 40, c);
      chk("first_tick_run_cycle", 1 + c, 4);
      wait_tick(0, 40, c);
      chk("tick_period", c, 4);
      wait_tick(1, 40, c);
      chk("first_baud_delay", c, 8);
      chk("idx_at_baud", sample_idx, 3);
      wait_tick(1, 40, c);
      chk("baud_period", c, 16);

      // fractional: divisor 4, dlf 8
      start(4, 0, 8, 3);
      wait_tick(0, 40, c);
      chk("frac_first", c, 4);
      wait_tick(0, 40, c);
      wait_tick(0, 40, c2);
`ifdef BAUD_FRAC_EN
      chk("frac_p2", c, 5);
      chk("frac_p3", c2, 4);
`else
      chk("frac_p2", c, 4);
      chk("frac_p3", c2, 4);
`endif

      // divisor 0 stops; divisor 1 psd 0 ticks every cycle
      start(0, 0, 0, 3);
      chk("div0_load_active", active, 0);
      cyc(10);
      chk("div0_idle_active", active, 0);
      chk("div0_idle_tick", sample_tick, 0);
      start(1, 0, 0, 3);
      chk("div1_load_tick", sample_tick, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("div1_tick_high", sample_tick, 1);
      end

      // restart mid-bit
      start(3, 0, 0, 4);
      c = 0;
      while (sample_idx != 2 && c < 100) begin cyc(1); c++; end
      chk("reach_idx2", sample_idx, 2);
      start(2, 0, 0, 3);
      chk("restart_load_ticks", {baud_tick, sample_tick}, 0);
      chk("restart_load_idx", sample_idx, 0);
      divisor_latch = DLW'(7);
      wait_tick(0, 40, c);
      chk("restart_first_tick", c, 2);
      wait_tick(0, 40, c);
      chk("ignored_divisor_change", c, 2);

      // reset dominates new_baud
      reset = 1'b1; new_baud = 1'b1;
      cyc(1);
      chk("reset_vs_new_baud", {active, baud_tick, sample_tick, 24'(sample_idx)}, 0);
      reset = 1'b0; new_baud = 1'b0;
      cyc(2);
      chk("after_reset_idle", active, 0);

      // osr=1 clamped to 3
      start(1, 0, 0, 1);
      wait_tick(1, 40, c);
      chk("osr_clamp_first_baud", c, 4);
      wait_tick(1, 40, c);
      chk("osr_clamp_baud_period", c, 4);

      cyc(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
